// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle between the multi-cycle controller and the R2000 datapath.
// The controller side is the master; the datapath side is the slave.
interface mips_multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       ALUZero;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       Mem2Reg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUCtl;
  logic       ExtOp;
  logic       IllegalInstr;
  logic       MemTimeout;
  logic [2:0] State;

  modport master (
    input  OpCode, Funct, ALUZero, MemReady,
    output PCWrite, PCSrc, IRWrite, IorD,
    output MemRead, MemWrite, RegWrite, RegDst,
    output Mem2Reg, ALUSrcA, ALUSrcB, ALUCtl,
    output ExtOp, IllegalInstr, MemTimeout, State
  );

  modport slave (
    output OpCode, Funct, ALUZero, MemReady,
    input  PCWrite, PCSrc, IRWrite, IorD,
    input  MemRead, MemWrite, RegWrite, RegDst,
    input  Mem2Reg, ALUSrcA, ALUSrcB, ALUCtl,
    input  ExtOp, IllegalInstr, MemTimeout, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle R2000 control FSM over a shared memory port with ready handshake.
// Optional MIPS_CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 0,
  parameter int CNT_W        = 8
) (
  input logic CLK,
  input logic RST,
  mips_multicycle_ctrl_if.master bus
`ifdef MIPS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstrCnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WB     = 3'd4,
    LDWB   = 3'd5,
    TRAP   = 3'd6,
    UNUSED = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WMAX = CNT_W'(MEM_WAIT_MAX);
  localparam bit TO_EN = MEM_WAIT_MAX > 0;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             to_flag;

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_j;
  logic is_imm_s, is_imm_z, is_supp;
  logic f_alu, f_jr;
  logic mem_state, to_hit, entering;

  assign is_r     = bus.OpCode == 6'h00;
  assign is_lw    = bus.OpCode == 6'h23;
  assign is_sw    = bus.OpCode == 6'h2B;
  assign is_beq   = bus.OpCode == 6'h04;
  assign is_bne   = bus.OpCode == 6'h05;
  assign is_j     = bus.OpCode == 6'h02;
  assign is_imm_s = bus.OpCode inside {6'h08, 6'h09, 6'h0A};
  assign is_imm_z = bus.OpCode inside {6'h0C, 6'h0D, 6'h0F};
  assign is_supp  = is_r | is_lw | is_sw | is_beq | is_bne
                  | is_imm_s | is_imm_z;
  assign f_alu    = bus.Funct inside {6'h20, 6'h21, 6'h22, 6'h23,
                                      6'h24, 6'h25, 6'h2A, 6'h00,
                                      6'h02};
  assign f_jr     = bus.Funct == 6'h08;

  // Ready in the limit cycle still completes the access.
  assign mem_state = (state == FETCH) || (state == MEMACC);
  assign to_hit    = TO_EN && mem_state && !bus.MemReady
                   && (cnt == WMAX);
  assign entering  = ((state_n == FETCH) && (state != FETCH))
                   || ((state_n == MEMACC) && (state != MEMACC));
  assign bus.State = state;

  always_comb begin
    state_n          = state;
    bus.PCWrite      = 1'b0;
    bus.PCSrc        = 2'b00;
    bus.IRWrite      = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.RegDst       = 1'b0;
    bus.Mem2Reg      = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUCtl       = 2'b00;
    bus.ExtOp        = 1'b0;
    bus.IllegalInstr = 1'b0;
    bus.MemTimeout   = 1'b0;
    if (RST) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          if (to_hit) begin
            bus.MemRead    = 1'b0;
            bus.MemTimeout = 1'b1;
            state_n        = TRAP;
          end else if (bus.MemReady) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            state_n     = DECODE;
          end
        end
        DECODE: begin
          bus.ALUSrcB = 2'b11;
          bus.ExtOp   = 1'b1;
          unique case (1'b1)
            is_j: begin
              bus.PCWrite = 1'b1;
              bus.PCSrc   = 2'b10;
              state_n     = FETCH;
            end
            is_supp: state_n = EXEC;
            default: state_n = TRAP;
          endcase
        end
        EXEC: begin
          unique case (1'b1)
            is_r && f_alu: begin
              bus.ALUSrcA = 1'b1;
              bus.ALUCtl  = 2'b10;
              state_n     = WB;
            end
            is_r && f_jr: begin
              bus.PCWrite = 1'b1;
              bus.PCSrc   = 2'b11;
              state_n     = FETCH;
            end
            is_lw || is_sw: begin
              bus.ALUSrcA = 1'b1;
              bus.ALUSrcB = 2'b10;
              bus.ExtOp   = 1'b1;
              state_n     = MEMACC;
            end
            is_imm_s || is_imm_z: begin
              bus.ALUSrcA = 1'b1;
              bus.ALUSrcB = 2'b10;
              bus.ALUCtl  = 2'b11;
              bus.ExtOp   = is_imm_s;
              state_n     = WB;
            end
            is_beq || is_bne: begin
              bus.ALUSrcA = 1'b1;
              bus.ALUCtl  = 2'b01;
              bus.PCSrc   = 2'b01;
              bus.PCWrite = (is_beq & bus.ALUZero)
                          | (is_bne & ~bus.ALUZero);
              state_n     = FETCH;
            end
            default: state_n = TRAP;
          endcase
        end
        MEMACC: begin
          bus.IorD     = 1'b1;
          bus.MemRead  = is_lw;
          bus.MemWrite = is_sw;
          if (to_hit) begin
            bus.MemRead    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.MemTimeout = 1'b1;
            state_n        = TRAP;
          end else if (bus.MemReady) begin
            state_n = is_lw ? LDWB : FETCH;
          end
        end
        WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = is_r;
          state_n      = FETCH;
        end
        LDWB: begin
          bus.RegWrite = 1'b1;
          bus.Mem2Reg  = 1'b1;
          state_n      = FETCH;
        end
        TRAP: begin
          bus.IllegalInstr = ~to_flag;
          state_n          = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= FETCH;
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_n;
      to_flag <= to_hit;
      if (entering) begin
        cnt <= '0;
      end else if (mem_state && !bus.MemReady && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic retire;

  assign retire = (state_n == FETCH) && (state != FETCH)
                && (state != TRAP);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + 32'd1;
      if (retire) begin
        InstrCnt <= InstrCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected outputs are queued
// by the stimulus and checked on the falling edge by an independent monitor.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] actl;
    logic       ext;
    logic       ill;
    logic       to;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } item_t;

  localparam exp_t ZERO    = '0;
  localparam exp_t RST_MEM = '{st:3'd3, default:'0};
  localparam exp_t F_WAIT  = '{st:3'd0, mr:1'b1, asb:2'b01, default:'0};
  localparam exp_t F_GO    = '{st:3'd0, mr:1'b1, asb:2'b01, irw:1'b1,
                               pcw:1'b1, default:'0};
  localparam exp_t DEC     = '{st:3'd1, asb:2'b11, ext:1'b1, default:'0};
  localparam exp_t DEC_J   = '{st:3'd1, asb:2'b11, ext:1'b1, pcw:1'b1,
                               pcsrc:2'b10, default:'0};
  localparam exp_t EX_R    = '{st:3'd2, asa:1'b1, actl:2'b10, default:'0};
  localparam exp_t EX_JR   = '{st:3'd2, pcw:1'b1, pcsrc:2'b11, default:'0};
  localparam exp_t EX_BAD  = '{st:3'd2, default:'0};
  localparam exp_t EX_MEM  = '{st:3'd2, asa:1'b1, asb:2'b10, ext:1'b1,
                               default:'0};
  localparam exp_t EX_IS   = '{st:3'd2, asa:1'b1, asb:2'b10, actl:2'b11,
                               ext:1'b1, default:'0};
  localparam exp_t EX_IZ   = '{st:3'd2, asa:1'b1, asb:2'b10, actl:2'b11,
                               default:'0};
  localparam exp_t EX_BR_T = '{st:3'd2, asa:1'b1, actl:2'b01, pcsrc:2'b01,
                               pcw:1'b1, default:'0};
  localparam exp_t EX_BR_N = '{st:3'd2, asa:1'b1, actl:2'b01, pcsrc:2'b01,
                               default:'0};
  localparam exp_t MEM_LW  = '{st:3'd3, iord:1'b1, mr:1'b1, default:'0};
  localparam exp_t MEM_SW  = '{st:3'd3, iord:1'b1, mw:1'b1, default:'0};
  localparam exp_t MEM_TO  = '{st:3'd3, iord:1'b1, to:1'b1, default:'0};
  localparam exp_t WB_R    = '{st:3'd4, rw:1'b1, rdst:1'b1, default:'0};
  localparam exp_t WB_I    = '{st:3'd4, rw:1'b1, default:'0};
  localparam exp_t LDWB    = '{st:3'd5, rw:1'b1, m2r:1'b1, default:'0};
  localparam exp_t TRAP_I  = '{st:3'd6, ill:1'b1, default:'0};
  localparam exp_t TRAP_T  = '{st:3'd6, default:'0};

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;
  item_t q[$];

  mips_multicycle_ctrl_if bus ();

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;
`endif

  mips_multicycle_ctrl #(
    .MEM_WAIT_MAX(4),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    .CycleCnt(CycleCnt),
    .InstrCnt(InstrCnt)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      item_t it;
      exp_t  g;
      it = q.pop_front();
      g = '{st:bus.State, pcw:bus.PCWrite, pcsrc:bus.PCSrc,
            irw:bus.IRWrite, iord:bus.IorD, mr:bus.MemRead,
            mw:bus.MemWrite, rw:bus.RegWrite, rdst:bus.RegDst,
            m2r:bus.Mem2Reg, asa:bus.ALUSrcA, asb:bus.ALUSrcB,
            actl:bus.ALUCtl, ext:bus.ExtOp, ill:bus.IllegalInstr,
            to:bus.MemTimeout};
      n_chk++;
      if (g !== it.e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d vec=%h, expected st=%0d vec=%h",
                 it.nm, g.st, g, it.e.st, it.e);
      end
    end
  end

  task automatic step(input string nm, input logic rdy,
                      input logic zero, input exp_t e);
    item_t it;
    bus.MemReady = rdy;
    bus.ALUZero  = zero;
    it.e  = e;
    it.nm = nm;
    q.push_back(it);
    @(posedge CLK);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    bus.OpCode = op;
    bus.Funct  = fn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b0;
    bus.OpCode   = 6'h00;
    bus.Funct    = 6'h00;
    bus.MemReady = 1'b0;
    bus.ALUZero  = 1'b0;
    @(posedge CLK);
    #1;
    step("reset", 1, 0, ZERO);
`ifdef MIPS_CTRL_PERF_CNT_EN
    n_chk++;
    if (CycleCnt !== 32'd0 || InstrCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d/%0d, expected 0/0",
               CycleCnt, InstrCnt);
    end
`endif
    RST = 1'b1;

    instr(6'h00, 6'h20);
    step("add_f", 1, 0, F_GO);
    step("add_d", 1, 0, DEC);
    step("add_e", 1, 0, EX_R);
    step("add_w", 1, 0, WB_R);

    instr(6'h23, 6'h00);
    step("lw_fw0", 0, 0, F_WAIT);
    step("lw_fw1", 0, 0, F_WAIT);
    step("lw_f", 1, 0, F_GO);
    step("lw_d", 0, 0, DEC);
    step("lw_e", 0, 0, EX_MEM);
    for (int i = 0; i < 3; i++) step("lw_mwait", 0, 0, MEM_LW);
    step("lw_mrdy", 1, 0, MEM_LW);
    step("lw_ldwb", 0, 0, LDWB);

    instr(6'h04, 6'h00);
    step("beq1_f", 1, 1, F_GO);
    step("beq1_d", 0, 1, DEC);
    step("beq1_e", 0, 1, EX_BR_T);
    step("beq0_f", 1, 0, F_GO);
    step("beq0_d", 0, 0, DEC);
    step("beq0_e", 0, 0, EX_BR_N);
    instr(6'h05, 6'h00);
    step("bne0_f", 1, 0, F_GO);
    step("bne0_d", 0, 0, DEC);
    step("bne0_e", 0, 0, EX_BR_T);
    step("bne1_f", 1, 1, F_GO);
    step("bne1_d", 0, 1, DEC);
    step("bne1_e", 0, 1, EX_BR_N);

    instr(6'h02, 6'h00);
    step("j_f", 1, 0, F_GO);
    step("j_d", 0, 0, DEC_J);

    instr(6'h00, 6'h08);
    step("jr_f", 1, 0, F_GO);
    step("jr_d", 0, 0, DEC);
    step("jr_e", 0, 0, EX_JR);

    instr(6'h0D, 6'h00);
    step("ori_f", 1, 0, F_GO);
    step("ori_d", 0, 0, DEC);
    step("ori_e", 0, 0, EX_IZ);
    step("ori_w", 0, 0, WB_I);

    instr(6'h08, 6'h00);
    step("addi_f", 1, 0, F_GO);
    step("addi_d", 0, 0, DEC);
    step("addi_e", 0, 0, EX_IS);
    step("addi_w", 0, 0, WB_I);

    instr(6'h3F, 6'h00);
    step("badop_f", 1, 0, F_GO);
    step("badop_d", 0, 0, DEC);
    step("badop_t", 0, 0, TRAP_I);

    instr(6'h00, 6'h3F);
    step("badfn_f", 1, 0, F_GO);
    step("badfn_d", 0, 0, DEC);
    step("badfn_e", 0, 0, EX_BAD);
    step("badfn_t", 0, 0, TRAP_I);

    instr(6'h2B, 6'h00);
    step("swto_f", 1, 0, F_GO);
    step("swto_d", 0, 0, DEC);
    step("swto_e", 0, 0, EX_MEM);
    for (int i = 0; i < 4; i++) step("swto_mwait", 0, 0, MEM_SW);
    step("swto_timeout", 0, 0, MEM_TO);
    step("swto_trap", 0, 0, TRAP_T);

    step("swlim_f", 1, 0, F_GO);
    step("swlim_d", 0, 0, DEC);
    step("swlim_e", 0, 0, EX_MEM);
    for (int i = 0; i < 4; i++) step("swlim_mwait", 0, 0, MEM_SW);
    step("swlim_rdy", 1, 0, MEM_SW);
    step("swlim_back", 0, 0, F_WAIT);
    step("swrst_f", 1, 0, F_GO);
    step("swrst_d", 0, 0, DEC);
    step("swrst_e", 0, 0, EX_MEM);
    step("swrst_m", 0, 0, MEM_SW);
    RST = 1'b0;
    step("swrst_abort", 0, 0, RST_MEM);
    step("swrst_state", 0, 0, ZERO);
`ifdef MIPS_CTRL_PERF_CNT_EN
    n_chk++;
    if (CycleCnt !== 32'd0 || InstrCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_midreset: got %0d/%0d, expected 0/0",
               CycleCnt, InstrCnt);
    end
`endif
    RST = 1'b1;
    step("post_rst", 0, 0, F_WAIT);

    @(negedge CLK);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
